// File: rtl/siaminer_pkg.sv
// Shared state encoding, result status codes and work-word field layout for the siaminer scheduler.
// The work word is 672 bits: header in [639:0], the 32 target bits that fit above it in [671:640].
package siaminer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } sched_state_e;

  localparam logic [1:0] STATUS_FOUND     = 2'd0;
  localparam logic [1:0] STATUS_EXHAUSTED = 2'd1;

  localparam int HDR_W     = 640;
  localparam int TGT_W     = 64;
  localparam int WORK_W    = 672;
  localparam int TGT_IN_W  = WORK_W - HDR_W;
  localparam int NONCE_W   = 32;
  localparam int NONCE_LSB = 256;

endpackage

// File: rtl/work_sched_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping at NCORE.
module rr_arb #(
  parameter int NCORE = 4,
  localparam int PW = (NCORE > 1) ? $clog2(NCORE) : 1
) (
  input  logic [NCORE-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [NCORE-1:0] o_grant
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;
  logic          w_hit;

  // Walk the requesters starting at the pointer; the first one found wins.
  always_comb begin
    o_grant = '0;
    w_hit   = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NCORE; k++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      w_sum = (w_sum >= (PW+1)'(NCORE)) ? (w_sum - (PW+1)'(NCORE)) : w_sum;
      w_idx = w_sum[PW-1:0];
      o_grant[w_idx] = o_grant[w_idx] | (~w_hit & i_req[w_idx]);
      w_hit = w_hit | i_req[w_idx];
    end
  end

endmodule

// File: rtl/work_sched.sv
// Work scheduler: slices each work's nonce space across NCORE hash cores and reports the first winner.
// Optional saturating statistics counters are built when SCHED_STATS_EN is defined.
module work_sched
  import siaminer_pkg::*;
#(
  parameter int NCORE      = 4,
  parameter int SLICE_LOG2 = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     work_valid,
  output logic                     work_ready,
  input  logic [WORK_W-1:0]        work_data,
  output logic [HDR_W-1:0]         core_work,
  output logic [TGT_W-1:0]         core_target,
  output logic [NCORE-1:0]         core_start,
  output logic [NONCE_W-1:0]       core_base,
  output logic                     core_abort,
  input  logic [NCORE-1:0]         core_busy,
  input  logic [NCORE-1:0]         core_found,
  input  logic [NCORE*NONCE_W-1:0] core_nonce,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [NONCE_W-1:0]       res_nonce,
  output logic [1:0]               res_status
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]              stat_slices,
  output logic [15:0]              stat_found
`endif
);

  localparam int PW = (NCORE > 1) ? $clog2(NCORE) : 1;

  sched_state_e       r_state, w_state_nxt;
  logic [HDR_W-1:0]   r_core_work, w_core_work_nxt;
  logic [TGT_W-1:0]   r_core_target, w_core_target_nxt;
  logic [NCORE-1:0]   r_core_start, w_core_start_nxt;
  logic [NONCE_W-1:0] r_core_base, w_core_base_nxt;
  logic               r_core_abort, w_core_abort_nxt;
  logic               r_res_valid, w_res_valid_nxt;
  logic [NONCE_W-1:0] r_res_nonce, w_res_nonce_nxt;
  logic [1:0]         r_res_status, w_res_status_nxt;
  logic [NONCE_W-1:0] r_next_nonce, w_next_nonce_nxt;
  logic               r_exhausted, w_exhausted_nxt;
  logic [PW-1:0]      r_rr_ptr, w_rr_ptr_nxt;

  logic               w_accept;
  logic               w_found_take;
  logic [NCORE-1:0]   w_req;
  logic [NCORE-1:0]   w_grant;
  logic [NCORE-1:0]   w_idle_oh;
  logic [PW-1:0]      w_win_idx;
  logic [NONCE_W-1:0] w_win_nonce;
  logic [NONCE_W:0]   w_nonce_sum;

  assign work_ready   = ~rst & (r_state != ST_REPORT);
  assign w_accept     = work_valid & work_ready;
  assign w_req        = core_found & core_busy;
  assign w_found_take = (r_state == ST_RUN) & ~w_accept & (|w_req);
  assign w_nonce_sum  = {1'b0, r_next_nonce} + (33'd1 << SLICE_LOG2);

  rr_arb #(.NCORE(NCORE)) u_rr_arb (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  // Decode the granted core's index/nonce and pick the lowest-index idle core.
  always_comb begin
    w_win_idx   = '0;
    w_win_nonce = '0;
    w_idle_oh   = '0;
    for (int i = NCORE-1; i >= 0; i--) begin
      w_win_idx   = w_win_idx | (PW'(i) & {PW{w_grant[i]}});
      w_win_nonce = w_win_nonce | (core_nonce[i*NONCE_W +: NONCE_W] & {NONCE_W{w_grant[i]}});
      w_idle_oh   = core_busy[i] ? w_idle_oh : (NCORE'(1) << i);
    end
  end

  // Next-state and next-output logic; new work always outranks a same-cycle found.
  always_comb begin
    w_state_nxt       = r_state;
    w_core_work_nxt   = r_core_work;
    w_core_target_nxt = r_core_target;
    w_core_start_nxt  = '0;
    w_core_base_nxt   = r_core_base;
    w_core_abort_nxt  = 1'b0;
    w_res_valid_nxt   = r_res_valid;
    w_res_nonce_nxt   = r_res_nonce;
    w_res_status_nxt  = r_res_status;
    w_next_nonce_nxt  = r_next_nonce;
    w_exhausted_nxt   = r_exhausted;
    w_rr_ptr_nxt      = r_rr_ptr;
    if (w_accept) begin
      w_state_nxt       = ST_RUN;
      w_core_work_nxt   = work_data[HDR_W-1:0];
      w_core_target_nxt = TGT_W'(work_data[WORK_W-1:HDR_W]);
      w_next_nonce_nxt  = work_data[NONCE_LSB +: NONCE_W];
      w_exhausted_nxt   = 1'b0;
      w_core_abort_nxt  = (r_state == ST_RUN);
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_RUN: begin
          if (w_found_take) begin
            w_state_nxt      = ST_REPORT;
            w_res_valid_nxt  = 1'b1;
            w_res_nonce_nxt  = w_win_nonce;
            w_res_status_nxt = STATUS_FOUND;
            w_core_abort_nxt = 1'b1;
            w_rr_ptr_nxt     = (w_win_idx == PW'(NCORE-1)) ? '0 : (w_win_idx + PW'(1));
          end else if (r_exhausted) begin
            if ((core_busy == '0) && (r_core_start == '0)) begin
              w_state_nxt      = ST_REPORT;
              w_res_valid_nxt  = 1'b1;
              w_res_nonce_nxt  = '0;
              w_res_status_nxt = STATUS_EXHAUSTED;
            end else begin
              w_state_nxt = ST_RUN;
            end
          end else if ((r_core_start == '0) && (|w_idle_oh)) begin
            w_core_start_nxt = w_idle_oh;
            w_core_base_nxt  = r_next_nonce;
            // A carry means the nonce space is used up; the wrapped value is never issued.
            if (w_nonce_sum[NONCE_W]) begin
              w_exhausted_nxt = 1'b1;
            end else begin
              w_next_nonce_nxt = w_nonce_sum[NONCE_W-1:0];
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_REPORT: begin
          if (r_res_valid && res_ready) begin
            w_state_nxt     = ST_IDLE;
            w_res_valid_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_REPORT;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and output registers; reset clears everything, so no abort leaves on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_core_work   <= '0;
      r_core_target <= '0;
      r_core_start  <= '0;
      r_core_base   <= '0;
      r_core_abort  <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_nonce   <= '0;
      r_res_status  <= 2'd0;
      r_next_nonce  <= '0;
      r_exhausted   <= 1'b0;
      r_rr_ptr      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_core_work   <= w_core_work_nxt;
      r_core_target <= w_core_target_nxt;
      r_core_start  <= w_core_start_nxt;
      r_core_base   <= w_core_base_nxt;
      r_core_abort  <= w_core_abort_nxt;
      r_res_valid   <= w_res_valid_nxt;
      r_res_nonce   <= w_res_nonce_nxt;
      r_res_status  <= w_res_status_nxt;
      r_next_nonce  <= w_next_nonce_nxt;
      r_exhausted   <= w_exhausted_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
    end
  end

  assign core_work   = r_core_work;
  assign core_target = r_core_target;
  assign core_start  = r_core_start;
  assign core_base   = r_core_base;
  assign core_abort  = r_core_abort;
  assign res_valid   = r_res_valid;
  assign res_nonce   = r_res_nonce;
  assign res_status  = r_res_status;

`ifdef SCHED_STATS_EN
  logic [31:0] r_stat_slices;
  logic [15:0] r_stat_found;

  // Saturating counts of issued slices and FOUND reports.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_slices <= 32'd0;
      r_stat_found  <= 16'd0;
    end else begin
      if ((|r_core_start) && (r_stat_slices != 32'hFFFF_FFFF)) begin
        r_stat_slices <= r_stat_slices + 32'd1;
      end
      if (w_found_take && (r_stat_found != 16'hFFFF)) begin
        r_stat_found <= r_stat_found + 16'd1;
      end
    end
  end

  assign stat_slices = r_stat_slices;
  assign stat_found  = r_stat_found;
`endif

endmodule

// File: tb/tb_work_sched.sv
// Self-checking bench for work_sched: a registered core model, scoreboarded slice starts and results.
module tb_work_sched;

  localparam int NCORE      = 4;
  localparam int SLICE_LOG2 = 24;
  localparam logic [31:0] TGT_BITS = 32'h00FF_EE11;

  logic         clk = 1'b0;
  logic         rst;
  logic         work_valid;
  logic         work_ready;
  logic [671:0] work_data;
  logic [639:0] core_work;
  logic [63:0]  core_target;
  logic [3:0]   core_start;
  logic [31:0]  core_base;
  logic         core_abort;
  logic [3:0]   core_busy;
  logic [3:0]   core_found;
  logic [127:0] core_nonce;
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  res_nonce;
  logic [1:0]   res_status;

  int n_cmp, n_err, cyc, n_abort;
  int          obs_idx[$];
  logic [31:0] obs_base[$];
  int          obs_cyc[$];
  int          exp_idx[$];
  logic [31:0] exp_base[$];
  int          exp_cyc[$];
  logic [31:0] exp_res_nonce[$];
  logic [1:0]  exp_res_status[$];

  always #5 clk = ~clk;

  work_sched #(.NCORE(NCORE), .SLICE_LOG2(SLICE_LOG2)) dut (
    .clk(clk), .rst(rst), .work_valid(work_valid), .work_ready(work_ready),
    .work_data(work_data), .core_work(core_work), .core_target(core_target),
    .core_start(core_start), .core_base(core_base), .core_abort(core_abort),
    .core_busy(core_busy), .core_found(core_found), .core_nonce(core_nonce),
    .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce),
    .res_status(res_status)
  );

  function automatic logic [639:0] make_hdr(input logic [31:0] nonce);
    logic [639:0] h;
    h = {20{32'h5A5A_C3C3}};
    h[287:256] = nonce;
    return h;
  endfunction

  // One clock; cores register busy from the start/abort seen before the edge, then outputs are logged.
  task automatic tick();
    logic [3:0] ps;
    logic       pa;
    ps = core_start;
    pa = core_abort;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NCORE; i++) begin
      if (pa) core_busy[i] = 1'b0;
      else if (ps[i]) core_busy[i] = 1'b1;
    end
    for (int i = 0; i < NCORE; i++) begin
      if (core_start[i]) begin
        obs_idx.push_back(i);
        obs_base.push_back(core_base);
        obs_cyc.push_back(cyc);
      end
    end
    if (core_abort) n_abort++;
  endtask

  task automatic clear_obs();
    obs_idx.delete();
    obs_base.delete();
    obs_cyc.delete();
  endtask

  task automatic send_work(input logic [31:0] nonce);
    work_data  = {TGT_BITS, make_hdr(nonce)};
    work_valid = 1'b1;
    tick();
    work_valid = 1'b0;
  endtask

  task automatic wait_res(output bit ok);
    for (int k = 0; k < 50 && !res_valid; k++) tick();
    ok = res_valid;
  endtask

  task automatic ack();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // Fill all cores from IDLE, then raise found on mask with per-core nonces 0xC0DE000i.
  task automatic run_found(input logic [3:0] mask, output bit ok);
    send_work(32'h2000_0000);
    repeat (9) tick();
    clear_obs();
    for (int i = 0; i < NCORE; i++) core_nonce[i*32 +: 32] = 32'hC0DE_0000 + i;
    core_found = mask;
    n_abort = 0;
    wait_res(ok);
    core_found = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (work_ready !== 1'b0) begin n_err++; $display("FAIL rst_work_ready got %b expected 0", work_ready); end
    n_cmp++; if (core_start !== 4'd0) begin n_err++; $display("FAIL rst_core_start got %b expected 0", core_start); end
    n_cmp++; if (core_abort !== 1'b0) begin n_err++; $display("FAIL rst_core_abort got %b expected 0", core_abort); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got %b expected 0", res_valid); end
    n_cmp++; if (res_nonce !== 32'd0 || res_status !== 2'd0) begin n_err++; $display("FAIL rst_res got %h/%0d expected 0/0", res_nonce, res_status); end
    n_cmp++; if (core_work !== 640'd0 || core_target !== 64'd0) begin n_err++; $display("FAIL rst_work_regs got target %h expected 0", core_target); end
    rst = 1'b0;
    tick();
    n_cmp++; if (work_ready !== 1'b1) begin n_err++; $display("FAIL idle_work_ready got %b expected 1", work_ready); end
    // found in IDLE must be ignored even when paired with busy
    n_abort = 0;
    core_busy = 4'hF;
    core_found = 4'hF;
    repeat (3) tick();
    n_cmp++; if (res_valid !== 1'b0 || n_abort !== 0) begin n_err++; $display("FAIL idle_found_ignored got valid %b aborts %0d expected 0 0", res_valid, n_abort); end
    core_busy = '0;
    core_found = '0;
    clear_obs();
  endtask

  task automatic test_starts();
    int acc;
    clear_obs();
    send_work(32'h1200_0000);
    acc = cyc;
    for (int k = 0; k < 4; k++) begin
      exp_idx.push_back(k);
      exp_base.push_back(32'h1200_0000 + k * 32'h0100_0000);
      exp_cyc.push_back(acc + 1 + 2 * k);
    end
    n_cmp++; if (core_work !== make_hdr(32'h1200_0000)) begin n_err++; $display("FAIL core_work got %h expected %h", core_work, make_hdr(32'h1200_0000)); end
    n_cmp++; if (core_target !== {32'd0, TGT_BITS}) begin n_err++; $display("FAIL core_target got %h expected %h", core_target, {32'd0, TGT_BITS}); end
    repeat (12) tick();
    while (exp_idx.size() > 0) begin
      int ei, ec;
      logic [31:0] eb;
      ei = exp_idx.pop_front(); eb = exp_base.pop_front(); ec = exp_cyc.pop_front();
      n_cmp++;
      if (obs_idx.size() == 0) begin
        n_err++; $display("FAIL start_missing got none expected core %0d base %h", ei, eb);
      end else begin
        int oi, oc;
        logic [31:0] ob;
        oi = obs_idx.pop_front(); ob = obs_base.pop_front(); oc = obs_cyc.pop_front();
        if (oi !== ei || ob !== eb || oc !== ec) begin
          n_err++; $display("FAIL start got core %0d base %h cyc %0d expected core %0d base %h cyc %0d", oi, ob, oc, ei, eb, ec);
        end
      end
    end
    n_cmp++; if (obs_idx.size() != 0) begin n_err++; $display("FAIL extra_starts got %0d expected 0", obs_idx.size()); end
  endtask

  task automatic test_found();
    bit ok;
    n_abort = 0;
    core_nonce[2*32 +: 32] = 32'h1400_0A5F;
    core_found = 4'b0100;
    exp_res_nonce.push_back(32'h1400_0A5F);
    exp_res_status.push_back(2'd0);
    wait_res(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL found_timeout got no res_valid expected res_valid"); end
    n_cmp++; if (res_nonce !== exp_res_nonce[0] || res_status !== exp_res_status[0]) begin n_err++; $display("FAIL found_res got %h/%0d expected %h/%0d", res_nonce, res_status, exp_res_nonce[0], exp_res_status[0]); end
    void'(exp_res_nonce.pop_front());
    void'(exp_res_status.pop_front());
    n_cmp++; if (core_abort !== 1'b1) begin n_err++; $display("FAIL found_abort got %b expected 1", core_abort); end
    core_found = '0;
    tick();
    n_cmp++; if (core_abort !== 1'b0 || n_abort !== 1) begin n_err++; $display("FAIL abort_pulse got %b count %0d expected 0 count 1", core_abort, n_abort); end
    ack();
    n_cmp++; if (res_valid !== 1'b0 || work_ready !== 1'b1) begin n_err++; $display("FAIL found_ack got valid %b ready %b expected 0 1", res_valid, work_ready); end
  endtask

  task automatic test_rr();
    bit ok;
    logic [3:0] masks [3];
    int         wins  [3];
    masks[0] = 4'b1000; wins[0] = 3;
    masks[1] = 4'b1010; wins[1] = 1;
    masks[2] = 4'b1010; wins[2] = 3;
    for (int r = 0; r < 3; r++) begin
      exp_res_nonce.push_back(32'hC0DE_0000 + wins[r]);
      run_found(masks[r], ok);
      n_cmp++;
      if (!ok || res_nonce !== exp_res_nonce[0] || res_status !== 2'd0) begin
        n_err++; $display("FAIL rr[%0d] got valid %b nonce %h status %0d expected nonce %h status 0", r, ok, res_nonce, res_status, exp_res_nonce[0]);
      end
      void'(exp_res_nonce.pop_front());
      ack();
    end
  endtask

  task automatic test_exhaust();
    bit ok;
    int acc;
    clear_obs();
    send_work(32'hFD00_0000);
    acc = cyc;
    for (int k = 0; k < 3; k++) begin
      exp_idx.push_back(k);
      exp_base.push_back(32'hFD00_0000 + k * 32'h0100_0000);
      exp_cyc.push_back(acc + 1 + 2 * k);
    end
    repeat (12) tick();
    while (exp_idx.size() > 0) begin
      int ei, ec;
      logic [31:0] eb;
      ei = exp_idx.pop_front(); eb = exp_base.pop_front(); ec = exp_cyc.pop_front();
      n_cmp++;
      if (obs_idx.size() == 0) begin
        n_err++; $display("FAIL exh_start_missing got none expected core %0d base %h", ei, eb);
      end else begin
        int oi, oc;
        logic [31:0] ob;
        oi = obs_idx.pop_front(); ob = obs_base.pop_front(); oc = obs_cyc.pop_front();
        if (oi !== ei || ob !== eb || oc !== ec) begin
          n_err++; $display("FAIL exh_start got core %0d base %h cyc %0d expected core %0d base %h cyc %0d", oi, ob, oc, ei, eb, ec);
        end
      end
    end
    n_cmp++; if (obs_idx.size() != 0) begin n_err++; $display("FAIL exh_extra_starts got %0d expected 0", obs_idx.size()); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL exh_early got valid %b expected 0", res_valid); end
    n_abort = 0;
    core_busy = '0;
    wait_res(ok);
    n_cmp++;
    if (!ok || res_nonce !== 32'd0 || res_status !== 2'd1 || n_abort !== 0) begin
      n_err++; $display("FAIL exhausted got valid %b nonce %h status %0d aborts %0d expected 1 0 1 0", ok, res_nonce, res_status, n_abort);
    end
    ack();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] en;
    en = 32'hC0DE_0002;
    run_found(4'b0100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_timeout got no res_valid expected res_valid"); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (res_valid !== 1'b1 || res_nonce !== en || work_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold[%0d] got valid %b nonce %h ready %b expected 1 %h 0", k, res_valid, res_nonce, work_ready, en);
      end
    end
    ack();
    n_cmp++; if (res_valid !== 1'b0 || work_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got valid %b ready %b expected 0 1", res_valid, work_ready); end
  endtask

  task automatic test_preempt();
    send_work(32'h3000_0000);
    repeat (9) tick();
    clear_obs();
    n_abort = 0;
    core_nonce[31:0] = 32'hDEAD_BEEF;
    core_found = 4'b0001;
    exp_idx.push_back(0);
    exp_base.push_back(32'h5000_0000);
    send_work(32'h5000_0000);
    core_found = '0;
    n_cmp++; if (core_abort !== 1'b1) begin n_err++; $display("FAIL preempt_abort got %b expected 1", core_abort); end
    repeat (4) tick();
    n_cmp++; if (res_valid !== 1'b0 || n_abort !== 1) begin n_err++; $display("FAIL preempt_found_dropped got valid %b aborts %0d expected 0 1", res_valid, n_abort); end
    n_cmp++;
    if (obs_idx.size() == 0) begin
      n_err++; $display("FAIL preempt_start got none expected core 0 base %h", exp_base[0]);
    end else if (obs_idx[0] !== exp_idx[0] || obs_base[0] !== exp_base[0]) begin
      n_err++; $display("FAIL preempt_start got core %0d base %h expected core %0d base %h", obs_idx[0], obs_base[0], exp_idx[0], exp_base[0]);
    end
    void'(exp_idx.pop_front());
    void'(exp_base.pop_front());
  endtask

  task automatic test_reset_midrun();
    n_abort = 0;
    rst = 1'b1;
    #1;
    n_cmp++; if (work_ready !== 1'b0) begin n_err++; $display("FAIL midrun_ready got %b expected 0", work_ready); end
    tick();
    n_cmp++; if (core_abort !== 1'b0 || n_abort !== 0 || core_start !== 4'd0 || core_work !== 640'd0) begin n_err++; $display("FAIL midrun_reset got abort %b start %b expected 0 0", core_abort, core_start); end
    rst = 1'b0;
    core_busy = '0;
    tick();
    tick();
    n_cmp++; if (work_ready !== 1'b1 || core_start !== 4'd0) begin n_err++; $display("FAIL midrun_idle got ready %b start %b expected 1 0", work_ready, core_start); end
  endtask

  initial begin
    rst = 1'b1;
    work_valid = 1'b0;
    work_data = '0;
    core_busy = '0;
    core_found = '0;
    core_nonce = '0;
    res_ready = 1'b0;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    n_abort = 0;
    test_reset();
    test_starts();
    test_found();
    test_rr();
    test_exhaust();
    test_backpressure();
    test_preempt();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
